// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, issues one word read at a time and hands each word to decode.
// Optional build macro FETCH_MISALIGN_TRAP_EN turns misaligned redirects into a sticky fault and halt.
module instruction_fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        reset,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic [31:0] mem_req_addr,
   input  logic        mem_resp_valid,
   input  logic [31:0] mem_resp_data,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        fetch_fault
);

`ifdef FETCH_MISALIGN_TRAP_EN
   typedef enum logic [1:0] {S_REQ, S_WAIT, S_OUT, S_HALT} state_t;
`else
   typedef enum logic [1:0] {S_REQ, S_WAIT, S_OUT} state_t;
`endif

   state_t      state;
   logic [31:0] pc;
   logic [31:0] inflight_pc;
   logic        drop;
   logic        handshake;
   logic [31:0] redirect_target;

   assign mem_req_addr = pc;
   assign handshake    = (state == S_REQ) && mem_req_valid && mem_req_ready;

`ifdef FETCH_MISALIGN_TRAP_EN
   logic misaligned;
   assign redirect_target = redirect_pc;
   assign misaligned      = redirect_valid && (redirect_pc[1:0] != 2'b00);
`else
   logic unused_low_bits;
   assign redirect_target = {redirect_pc[31:2], 2'b00};
   assign unused_low_bits = ^redirect_pc[1:0];
   assign fetch_fault     = 1'b0;
`endif

   // A redirect always wins; drop marks a response that is still owed but no longer wanted.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= S_REQ;
         pc            <= RESET_PC;
         inflight_pc   <= 32'h0;
         drop          <= 1'b0;
         instr         <= NOP_INSTR;
         instr_pc      <= 32'h0;
         instr_valid   <= 1'b0;
         mem_req_valid <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
         fetch_fault   <= 1'b0;
`endif
      end else begin
`ifdef FETCH_MISALIGN_TRAP_EN
         if (state != S_HALT && misaligned) begin
            state         <= S_HALT;
            fetch_fault   <= 1'b1;
            instr_valid   <= 1'b0;
            instr         <= NOP_INSTR;
            mem_req_valid <= 1'b0;
         end else
`endif
         case (state)
            S_REQ: begin
               if (redirect_valid) pc <= redirect_target;
               if (handshake) begin
                  inflight_pc   <= pc;
                  drop          <= redirect_valid;
                  mem_req_valid <= 1'b0;
                  state         <= S_WAIT;
               end else begin
                  mem_req_valid <= 1'b1;
               end
            end
            S_WAIT: begin
               if (mem_resp_valid) begin
                  if (redirect_valid || drop) begin
                     if (redirect_valid) pc <= redirect_target;
                     drop          <= 1'b0;
                     mem_req_valid <= 1'b1;
                     state         <= S_REQ;
                  end else begin
                     instr       <= mem_resp_data;
                     instr_pc    <= inflight_pc;
                     pc          <= inflight_pc + 32'd4;
                     instr_valid <= 1'b1;
                     state       <= S_OUT;
                  end
               end else if (redirect_valid) begin
                  pc   <= redirect_target;
                  drop <= 1'b1;
               end
            end
            S_OUT: begin
               if (redirect_valid || instr_ready) begin
                  if (redirect_valid) pc <= redirect_target;
                  instr_valid   <= 1'b0;
                  instr         <= NOP_INSTR;
                  mem_req_valid <= 1'b1;
                  state         <= S_REQ;
               end
            end
`ifdef FETCH_MISALIGN_TRAP_EN
            S_HALT: begin
            end
`endif
            default: begin
               state <= S_REQ;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Randomized bench for instruction_fetch_unit with a transaction-level fetch model and a toy memory.
// Honours FETCH_MISALIGN_TRAP_EN the same way the design does.
module tb_instruction_fetch_unit;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        reset;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [31:0] mem_req_addr;
   logic        mem_resp_valid;
   logic [31:0] mem_resp_data;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        fetch_fault;

   instruction_fetch_unit dut (
      .clk(clk), .reset(reset),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
      .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
      .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .fetch_fault(fetch_fault)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // Stimulus knobs and toy memory state.
   int          pct_ready, pct_iready, pct_redir, max_lat;
   logic        force_en;
   logic [31:0] force_pc;
   int          mem_cnt;
   logic [31:0] mem_addr;

   // Reference model: what decode and memory should see, in transaction terms.
   logic [31:0] m_pc, m_out_addr, m_hold_pc, m_hold_data;
   logic        m_outstanding, m_stale, m_holding, m_halt, m_fault;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", tag, observed, expected, $time);
      end
   endtask

   function automatic logic [31:0] memWord(input logic [31:0] a);
      return 32'h0050_0093 ^ (a * 32'h9E37_79B9);
   endfunction

   function automatic logic [31:0] pickTarget();
      logic [31:0] t;
      case ($urandom_range(3))
         0:       t = 32'hFFFF_FFFC;
         1:       t = 32'hFFFF_FFF0 | ($urandom & 32'hC);
         default: t = $urandom & 32'h0000_0FFC;
      endcase
`ifndef FETCH_MISALIGN_TRAP_EN
      t[1:0] = 2'($urandom_range(3));
`endif
      return t;
   endfunction

   task automatic applyStimulus();
      logic exp_req, acc, misal;
      @(posedge clk);
      #1;
      mem_resp_valid = 1'b0;
      mem_resp_data  = $urandom;
      if (mem_cnt > 0) begin
         mem_cnt--;
         if (mem_cnt == 0) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = memWord(mem_addr);
         end
      end
      mem_req_ready  = ($urandom_range(99) < pct_ready);
      instr_ready    = ($urandom_range(99) < pct_iready);
      redirect_valid = ($urandom_range(99) < pct_redir);
      redirect_pc    = redirect_valid ? pickTarget() : $urandom;
      if (force_en) begin
         redirect_valid = 1'b1;
         redirect_pc    = force_pc;
         force_en       = 1'b0;
      end
      @(negedge clk);

      exp_req = !m_outstanding && !m_holding && !m_halt;
      checkOutput("req_valid", {31'b0, mem_req_valid}, {31'b0, exp_req});
      if (!m_halt) checkOutput("req_addr", mem_req_addr, m_pc);
      checkOutput("instr_valid", {31'b0, instr_valid}, {31'b0, m_holding});
      checkOutput("instr", instr, m_holding ? m_hold_data : NOP);
      if (!m_halt) checkOutput("instr_pc", instr_pc, m_hold_pc);
      checkOutput("fetch_fault", {31'b0, fetch_fault}, {31'b0, m_fault});

      if (mem_req_valid && mem_req_ready) begin
         mem_cnt  = $urandom_range(max_lat, 1);
         mem_addr = mem_req_addr;
      end

      if (!m_halt) begin
         acc = exp_req && mem_req_ready;
         if (m_holding && instr_ready) m_holding = 1'b0;
         if (mem_resp_valid && m_outstanding) begin
            m_outstanding = 1'b0;
            if (!m_stale && !redirect_valid) begin
               m_holding   = 1'b1;
               m_hold_pc   = m_out_addr;
               m_hold_data = memWord(m_out_addr);
               m_pc        = m_out_addr + 32'd4;
            end
         end
         if (acc) begin
            m_outstanding = 1'b1;
            m_out_addr    = m_pc;
            m_stale       = 1'b0;
         end
         if (redirect_valid) begin
            misal = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
            misal = (redirect_pc[1:0] != 2'b00);
`endif
            m_holding = 1'b0;
            if (misal) begin
               m_halt  = 1'b1;
               m_fault = 1'b1;
            end else begin
               m_pc = redirect_pc & 32'hFFFF_FFFC;
               if (m_outstanding) m_stale = 1'b1;
            end
         end
      end
   endtask

   initial begin
      reset          = 1'b1;
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
      mem_resp_data  = 32'h0;
      instr_ready    = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      force_en       = 1'b0;
      force_pc       = 32'h0;
      mem_cnt        = 0;
      mem_addr       = 32'h0;
      m_pc = 32'h0; m_out_addr = 32'h0; m_hold_pc = 32'h0; m_hold_data = NOP;
      m_outstanding = 1'b0; m_stale = 1'b0; m_holding = 1'b0; m_halt = 1'b0; m_fault = 1'b0;

      repeat (2) @(negedge clk);
      checkOutput("rst_req_valid", {31'b0, mem_req_valid}, 32'h0);
      checkOutput("rst_req_addr", mem_req_addr, 32'h0);
      checkOutput("rst_instr_valid", {31'b0, instr_valid}, 32'h0);
      checkOutput("rst_instr", instr, NOP);
      checkOutput("rst_instr_pc", instr_pc, 32'h0);
      checkOutput("rst_fault", {31'b0, fetch_fault}, 32'h0);
      reset = 1'b0;

      // Ideal memory and decode: back-to-back sequential fetch from address 0.
      pct_ready = 100; pct_iready = 100; pct_redir = 0; max_lat = 1;
      repeat (30) applyStimulus();

      // Slow decode and jittery memory: held instructions must stay put.
      pct_ready = 60; pct_iready = 15; max_lat = 4;
      repeat (300) applyStimulus();

      // Everything random, including redirects in every state.
      pct_ready = 60; pct_iready = 50; pct_redir = 10; max_lat = 3;
      repeat (3000) applyStimulus();

      // Misaligned target: masked to 0x100, or a halt when trapping is built in.
      pct_redir = 0;
      force_en = 1'b1; force_pc = 32'h0000_0102;
      repeat (40) applyStimulus();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Fetch stage that sits directly upstream of the instruction control extractor and decode logic.
- Owns the program counter and issues word reads to instruction memory over a valid/ready request channel, with a single-cycle response channel.
- Presents each fetched instruction word, together with its PC, to decode over a valid/ready handshake.
- Accepts redirects (taken branch, JAL, JALR) from execute and discards stale in-flight data.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset and used as the first fetch address.
- NOP_INSTR, 32'h0000_0013, value driven on instr while no valid instruction is held (addi x0,x0,0).

Ports:
- clk  in  1  single system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- mem_req_valid  out  1  fetch request valid.
- mem_req_ready  in  1  memory accepts the request this cycle.
- mem_req_addr  out  32  word-aligned fetch address.
- mem_resp_valid  in  1  response data valid; pulses exactly once per accepted request, at least 1 cycle after acceptance.
- mem_resp_data  in  32  fetched instruction word.
- instr_valid  out  1  instr and instr_pc are valid for decode.
- instr_ready  in  1  decode consumes the instruction this cycle.
- instr  out  32  instruction word, feeding the control extractor's instr input.
- instr_pc  out  32  address of instr.
- redirect_valid  in  1  execute requests a PC change.
- redirect_pc  in  32  new PC.
- fetch_fault  out  1  misaligned redirect fault; only meaningful with the optional feature, otherwise constant 0.

Behaviour:
- Reset (asynchronous, any state): state=S_REQ, pc=RESET_PC, drop=0, instr=NOP_INSTR, instr_pc=0, instr_valid=0, mem_req_valid=0 until the first edge after deassertion, fetch_fault=0. The memory side is reset by the same signal, so no pre-reset response arrives afterwards.
- Outputs: all outputs are registered or decoded from state only. There is no combinational path from any input to any output.
- S_REQ:
  - mem_req_valid=1 and mem_req_addr=pc; both are held stable until mem_req_ready.
  - Handshake (valid&ready): latch inflight_pc=pc and go to S_WAIT.
- S_WAIT:
  - mem_req_valid=0.
  - On mem_resp_valid with drop=0: instr<=mem_resp_data, instr_pc<=inflight_pc, pc<=inflight_pc+4 (mod 2^32, wraps 0xFFFF_FFFC->0), instr_valid<=1, go to S_OUT.
  - On mem_resp_valid with drop=1: discard the data, clear drop, go to S_REQ.
- S_OUT:
  - instr_valid=1; instr and instr_pc are held stable until instr_ready.
  - On instr_ready: instr_valid<=0, instr<=NOP_INSTR, go to S_REQ.
- mem_resp_valid outside S_WAIT is ignored.
- Latency: request issue to instr_valid is memory latency + 1 cycle. Best-case throughput is one instruction per 3 cycles (single outstanding request).
- Redirect has priority over every other event in the same cycle:
  - S_REQ with or without handshake: pc<=redirect_pc. If the handshake also occurred, go to S_WAIT with drop=1; otherwise stay in S_REQ.
  - S_WAIT: pc<=redirect_pc, drop<=1. If mem_resp_valid is in the same cycle, drop that response and go to S_REQ.
  - S_OUT (including a same-cycle instr_ready): discard the held instruction, instr_valid<=0, pc<=redirect_pc, go to S_REQ.
  - A redirect while drop=1 only updates pc again; drop stays 1.
- Without the optional feature, redirect_pc[1:0] is forced to 2'b00 when loaded.

Optional Feature:
- Macro FETCH_MISALIGN_TRAP_EN.
- Defined: a redirect with redirect_pc[1:0]!=0 sets fetch_fault<=1 (sticky until reset), moves to S_HALT, and clears instr_valid.
  - S_HALT never asserts mem_req_valid or instr_valid and ignores all inputs.
  - An outstanding response is absorbed silently.
- Undefined: no S_HALT state, fetch_fault is tied to 0, and the low bits are masked as described above.

Test Plan:
- Reset pulse, mem_req_ready=1, 1-cycle memory returning 0x00500093 -> first mem_req_addr=0x0, instr=0x00500093, instr_pc=0x0, next request addr=0x4.
- Three sequential fetches with instr_ready=1 -> instr_pc 0x0, 0x4, 0x8; one instruction per 3 cycles.
- Hold instr_ready=0 for 5 cycles in S_OUT -> instr and instr_pc stable; no new mem_req_valid until the cycle after instr_ready=1.
- Redirect to 0x100 while in S_WAIT -> the next mem_resp is dropped (instr_valid stays 0); the next request addr is 0x100.
- Redirect to 0x200 in the same cycle as instr_ready in S_OUT -> the held instruction is discarded; the next mem_req_addr is 0x200.
- With FETCH_MISALIGN_TRAP_EN, redirect to 0x102 -> fetch_fault=1 and no further mem_req_valid. Without the macro, the next mem_req_addr is 0x100.
